// File: rtl/seg7_scan_reader.sv
// Decodes a multiplexed active-low 7-segment bus back into BCD digits and
// presents each completed frame on a valid/ready interface.
module seg7_scan_reader #(
  parameter int N_DIG  = 4,
  parameter int STABLE = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           seg_n,
  input  logic [N_DIG-1:0]     an_n,
  output logic [4*N_DIG-1:0]   digits,
  output logic [N_DIG-1:0]     dig_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun
);

  // The counter reaches STABLE+1 and saturates there, so each run captures once.
  localparam int CW = $clog2(STABLE + 2);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE);
  localparam logic [CW-1:0] CNT_SAT = CW'(STABLE + 1);

  logic [N_DIG-1:0]   r_an;
  logic [6:0]         r_seg;
  logic [CW-1:0]      r_cnt;
  logic [N_DIG-1:0]   r_seen;
  logic [4*N_DIG-1:0] r_shadow;
  logic [N_DIG-1:0]   r_shadow_err;
  logic [4*N_DIG-1:0] r_digits;
  logic [N_DIG-1:0]   r_err;
  logic               r_valid;
  logic               r_overrun;

  logic               w_in_valid;
  logic               w_match;
  logic               w_capture;
  logic               w_frame;
  logic [4:0]         w_dec;
  logic [CW-1:0]      w_cnt_nx;
  logic [N_DIG-1:0]   w_seen_nx;
  logic [4*N_DIG-1:0] w_shadow_nx;
  logic [N_DIG-1:0]   w_shadow_err_nx;
  logic [4*N_DIG-1:0] w_digits_nx;
  logic [N_DIG-1:0]   w_err_nx;
  logic               w_valid_nx;
  logic               w_overrun_nx;

  function automatic logic one_low(input logic [N_DIG-1:0] an);
    int zeros;
    zeros = 0;
    for (int i = 0; i < N_DIG; i++) begin
      if (!an[i]) zeros++;
    end
    return (zeros == 1);
  endfunction

  // Returns {error, nibble}; unknown patterns (including blank) map to 0xF.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'h40:   return 5'h00;
      7'h79:   return 5'h01;
      7'h24:   return 5'h02;
      7'h30:   return 5'h03;
      7'h19:   return 5'h04;
      7'h12:   return 5'h05;
      7'h02:   return 5'h06;
      7'h78:   return 5'h07;
      7'h00:   return 5'h08;
      7'h10:   return 5'h09;
      default: return 5'h1F;
    endcase
  endfunction

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    w_in_valid      = one_low(an_n);
    w_match         = (an_n == r_an) && (seg_n == r_seg) && (r_cnt != '0);
    w_cnt_nx        = '0;
    w_capture       = (r_cnt == CNT_CAP);
    w_dec           = decode(r_seg);
    w_seen_nx       = r_seen;
    w_shadow_nx     = r_shadow;
    w_shadow_err_nx = r_shadow_err;
    w_digits_nx     = r_digits;
    w_err_nx        = r_err;
    w_valid_nx      = r_valid;
    w_overrun_nx    = r_overrun;

    if (w_in_valid) begin
      if (w_match) w_cnt_nx = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;
      else         w_cnt_nx = CW'(1);
    end

    // Capture works off the registered run, so a change on this edge does not block it.
    for (int i = 0; i < N_DIG; i++) begin
      if (w_capture && !r_an[i]) begin
        w_shadow_nx[4*i +: 4] = w_dec[3:0];
        w_shadow_err_nx[i]    = w_dec[4];
        w_seen_nx[i]          = 1'b1;
      end
    end
    w_frame = w_capture && (&w_seen_nx);

    if (r_valid && out_ready) w_valid_nx = 1'b0;

    if (w_frame) begin
      w_seen_nx = '0;
      if (!r_valid || out_ready) begin
        w_digits_nx = w_shadow_nx;
        w_err_nx    = w_shadow_err_nx;
        w_valid_nx  = 1'b1;
      end else begin
        w_overrun_nx = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_an         <= '1;
      r_seg        <= '1;
      r_cnt        <= '0;
      r_seen       <= '0;
      r_shadow     <= '0;
      r_shadow_err <= '0;
      r_digits     <= '0;
      r_err        <= '0;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_an         <= an_n;
      r_seg        <= seg_n;
      r_cnt        <= w_cnt_nx;
      r_seen       <= w_seen_nx;
      r_shadow     <= w_shadow_nx;
      r_shadow_err <= w_shadow_err_nx;
      r_digits     <= w_digits_nx;
      r_err        <= w_err_nx;
      r_valid      <= w_valid_nx;
      r_overrun    <= w_overrun_nx;
    end
  end

  assign digits    = r_digits;
  assign dig_err   = r_err;
  assign out_valid = r_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader: scans hand-built frames and checks
// the captured digits, error flags and handshake/overrun behaviour.
module tb_seg7_scan_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] digits;
  logic [3:0]  dig_err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int vcnt;
  logic [15:0] last_digits;
  logic [3:0]  last_err;

  always #5 clk = ~clk;

  seg7_scan_reader #(.N_DIG(4), .STABLE(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .seg_n    (seg_n),
    .an_n     (an_n),
    .digits   (digits),
    .dig_err  (dig_err),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun  (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hold one select/segment pair for n edges, sampling outputs 1 ns after each edge.
  task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_n  = an;
    seg_n = seg;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        vcnt++;
        last_digits = digits;
        last_err    = dig_err;
      end
    end
  endtask

  task automatic idle(input int n);
    show(4'b1111, 7'h7F, n);
  endtask

  task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    show(4'b1110, s0, 5);
    show(4'b1101, s1, 5);
    show(4'b1011, s2, 5);
    show(4'b0111, s3, 5);
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    an_n      = 4'b1111;
    seg_n     = 7'h7F;
    vcnt      = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_err", 32'(dig_err), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Basic frame 1,2,3,4 with ready high: one valid cycle.
    vcnt = 0;
    scan4(7'h79, 7'h24, 7'h30, 7'h19);
    idle(3);
    check("t1_vcnt", 32'(vcnt), 32'd1);
    check("t1_digits", 32'(last_digits), 32'h4321);
    check("t1_err", 32'(last_err), 32'h0);
    check("t1_overrun", 32'(overrun), 32'h0);
    check("t1_valid_low", 32'(out_valid), 32'h0);

    // A run one edge short of STABLE must not be captured.
    vcnt = 0;
    show(4'b1110, 7'h79, 2);
    show(4'b1110, 7'h24, 3);
    show(4'b1101, 7'h40, 5);
    show(4'b1011, 7'h40, 5);
    show(4'b0111, 7'h40, 5);
    idle(3);
    check("t2_vcnt", 32'(vcnt), 32'd1);
    check("t2_digits", 32'(last_digits), 32'h0002);
    check("t2_err", 32'(last_err), 32'h0);

    // Blank digit decodes to F with its error bit.
    vcnt = 0;
    scan4(7'h10, 7'h10, 7'h7F, 7'h10);
    idle(3);
    check("t3_vcnt", 32'(vcnt), 32'd1);
    check("t3_digits", 32'(last_digits), 32'h9F99);
    check("t3_err", 32'(last_err), 32'b0100);

    // Backpressure: second frame dropped, first held, overrun sticky.
    out_ready = 1'b0;
    scan4(7'h12, 7'h02, 7'h78, 7'h00);
    idle(2);
    check("t4_valid1", 32'(out_valid), 32'h1);
    check("t4_digits1", 32'(digits), 32'h8765);
    check("t4_ovr1", 32'(overrun), 32'h0);
    scan4(7'h40, 7'h40, 7'h40, 7'h40);
    idle(2);
    check("t4_digits2", 32'(digits), 32'h8765);
    check("t4_ovr2", 32'(overrun), 32'h1);
    check("t4_valid2", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t4_valid_acc", 32'(out_valid), 32'h0);
    check("t4_ovr_sticky", 32'(overrun), 32'h1);
    idle(2);

    // Invalid selects never capture; a later 3-digit scan must not finish a frame.
    vcnt = 0;
    show(4'b0011, 7'h00, 10);
    show(4'b1111, 7'h00, 10);
    check("t5_vcnt_inv", 32'(vcnt), 32'd0);
    show(4'b1101, 7'h79, 5);
    show(4'b1011, 7'h24, 5);
    show(4'b0111, 7'h30, 5);
    idle(2);
    check("t5_vcnt_3dig", 32'(vcnt), 32'd0);

    // Reset with three digits pending discards them.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("t6_digits", 32'(digits), 32'h0);
    check("t6_err", 32'(dig_err), 32'h0);
    check("t6_valid", 32'(out_valid), 32'h0);
    check("t6_overrun", 32'(overrun), 32'h0);
    vcnt = 0;
    show(4'b1110, 7'h19, 5);
    idle(2);
    check("t6_no_frame", 32'(vcnt), 32'd0);
    show(4'b1101, 7'h12, 5);
    show(4'b1011, 7'h02, 5);
    show(4'b0111, 7'h78, 5);
    idle(3);
    check("t6_vcnt", 32'(vcnt), 32'd1);
    check("t6_frame", 32'(last_digits), 32'h7654);
    check("t6_frame_err", 32'(last_err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
